// File: rtl/instr_sequencer_pkg.sv
// Shared types and constants for the instruction sequencer: FSM states,
// opcode encodings and the default ALU wait timeout.
package instr_sequencer_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_DECODE,
        S_EXEC,
        S_WAIT,
        S_WB,
        S_HALT
    } state_e;

    localparam logic [2:0] OP_ADD  = 3'b000;
    localparam logic [2:0] OP_SUB  = 3'b001;
    localparam logic [2:0] OP_MUL  = 3'b010;
    localparam logic [2:0] OP_DIV  = 3'b011;
    localparam logic [2:0] OP_MOD  = 3'b100;
    localparam logic [2:0] OP_CMP  = 3'b101;
    localparam logic [2:0] OP_NOP  = 3'b110;
    localparam logic [2:0] OP_HALT = 3'b111;

    localparam int TIMEOUT_DEF = 15;

    function automatic logic is_multicycle(input logic [2:0] op);
        return (op == OP_DIV) || (op == OP_MOD);
    endfunction

    function automatic logic writes_back(input logic [2:0] op);
        return op <= OP_MOD;
    endfunction

endpackage

// File: rtl/seq_watchdog.sv
// Wait-cycle counter for multi-cycle ALU ops; expired_o flags the last
// permitted WAIT cycle so the FSM can give up without an extra cycle.
module seq_watchdog #(
    parameter int TIMEOUT = 15
) (
    input  logic clock,
    input  logic reset,
    input  logic clear_i,
    input  logic cnt_en_i,
    output logic expired_o
);
    localparam int CW = $clog2(TIMEOUT + 1);

    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clear_i)
            cnt_d = '0;
        else if (cnt_en_i)
            cnt_d = cnt_q + 1'b1;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset)
            cnt_q <= '0;
        else
            cnt_q <= cnt_d;
    end

    assign expired_o = (cnt_q == CW'(TIMEOUT - 1));

endmodule

// File: rtl/instr_sequencer.sv
// Fetch/decode/execute/write-back sequencer walking a program of up to 16
// instructions from a synchronous instruction memory.
module instr_sequencer
    import instr_sequencer_pkg::*;
#(
    parameter int TIMEOUT = TIMEOUT_DEF
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       ena,
    input  logic       start,
    input  logic [3:0] prog_len,
    output logic [3:0] imem_addr,
    input  logic [7:0] imem_data,
    output logic [7:0] dec_instr,
    output logic       dec_ena,
    input  logic       alu_done,
    output logic       wb_strobe,
    output logic       busy,
    output logic       done,
    output logic       error,
    output logic [3:0] pc
);
    state_e     state_q, state_d;
    logic [3:0] pc_q, pc_d;
    logic [3:0] len_q, len_d;
    logic [7:0] instr_q, instr_d;
    logic       err_q, err_d;
    logic       wd_clear, wd_cnt, wd_expired;
    logic [2:0] opcode;

    assign opcode = instr_q[7:5];

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            pc_q    <= '0;
            len_q   <= '0;
            instr_q <= '0;
            err_q   <= 1'b0;
        end else if (ena) begin
            state_q <= state_d;
            pc_q    <= pc_d;
            len_q   <= len_d;
            instr_q <= instr_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        len_d     = len_q;
        instr_d   = instr_q;
        err_d     = err_q;
        dec_ena   = 1'b0;
        wb_strobe = 1'b0;
        wd_clear  = 1'b0;
        wd_cnt    = 1'b0;
        case (state_q)
            S_IDLE, S_HALT: begin
                if (start) begin
                    state_d = S_FETCH;
                    pc_d    = '0;
                    len_d   = prog_len;
                    err_d   = 1'b0;
                end
            end
            S_FETCH:  state_d = S_DECODE;
            S_DECODE: begin
                instr_d = imem_data;
                dec_ena = ena;
                state_d = S_EXEC;
            end
            S_EXEC: begin
                wd_clear = ena;
                state_d  = is_multicycle(opcode) ? S_WAIT : S_WB;
            end
            S_WAIT: begin
                // alu_done wins over expiry so a completion on the last cycle still commits
                if (alu_done) begin
                    state_d = S_WB;
                end else if (wd_expired) begin
                    err_d   = 1'b1;
                    state_d = S_HALT;
                end else begin
                    wd_cnt = ena;
                end
            end
            S_WB: begin
                wb_strobe = ena && writes_back(opcode);
                if (opcode == OP_HALT || pc_q == len_q || pc_q == 4'hF) begin
                    state_d = S_HALT;
                end else begin
                    pc_d    = pc_q + 4'd1;
                    state_d = S_FETCH;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    seq_watchdog #(.TIMEOUT(TIMEOUT)) u_watchdog (
        .clock     (clock),
        .reset     (reset),
        .clear_i   (wd_clear),
        .cnt_en_i  (wd_cnt),
        .expired_o (wd_expired)
    );

    assign imem_addr = pc_q;
    assign pc        = pc_q;
    assign dec_instr = instr_q;
    assign error     = err_q;
    assign done      = (state_q == S_HALT);
    assign busy      = (state_q == S_FETCH) || (state_q == S_DECODE) || (state_q == S_EXEC)
                    || (state_q == S_WAIT) || (state_q == S_WB);

endmodule

// File: tb/tb_instr_sequencer.sv
// Bench for instr_sequencer: directed program table, multi-cycle corner
// sequences, and random programs against a program-level reference model.
module tb_instr_sequencer;
    localparam int TO = 15;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       ena = 1'b0;
    logic       start = 1'b0;
    logic       alu_done = 1'b0;
    logic [3:0] prog_len = '0;
    logic [3:0] imem_addr, pc;
    logic [7:0] imem_data, dec_instr;
    logic       dec_ena, wb_strobe, busy, done, error;

    logic [7:0] mem [16];
    logic [4:0] dly [16];

    int checks = 0;
    int errors = 0;
    int wb_q[$];
    int exp_wb[$];
    int act_cyc = 0;

    typedef struct {
        logic [15:0][7:0] prog;
        logic [15:0][4:0] dl;
        logic [3:0]       len;
        int               n_wb;
        int               fpc;
        int               ferr;
        int               cyc;
    } vec_t;
    vec_t tbl[8];

    instr_sequencer #(.TIMEOUT(TO)) dut (
        .clock     (clock),
        .reset     (reset),
        .ena       (ena),
        .start     (start),
        .prog_len  (prog_len),
        .imem_addr (imem_addr),
        .imem_data (imem_data),
        .dec_instr (dec_instr),
        .dec_ena   (dec_ena),
        .alu_done  (alu_done),
        .wb_strobe (wb_strobe),
        .busy      (busy),
        .done      (done),
        .error     (error),
        .pc        (pc)
    );

    always #5 clock = ~clock;

    always @(posedge clock) imem_data <= mem[imem_addr];

    always @(negedge clock) begin
        if (wb_strobe) wb_q.push_back(int'(pc));
        if (busy && ena) act_cyc++;
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic step(input bit e, input bit s, input bit a);
        @(posedge clock);
        #1;
        ena = e; start = s; alu_done = a;
        @(negedge clock);
    endtask

    task automatic wait_dec(input string nm);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            step(1, 0, 0);
            seen = dec_ena;
        end
        chk({nm, "_dec_seen"}, 32'(seen), 1);
    endtask

    // Program-level model: walk instructions, add up enabled busy cycles.
    task automatic model(input int len, output int fpc, output int ferr, output int fcyc);
        int op;
        exp_wb.delete();
        fpc = 0; ferr = 0; fcyc = 0;
        for (int p = 0; p < 16; p++) begin
            op  = int'(mem[p][7:5]);
            fpc = p;
            if (op == 3 || op == 4) begin
                if (int'(dly[p]) > TO) begin
                    fcyc += 3 + TO;
                    ferr = 1;
                    break;
                end
                fcyc += 4 + int'(dly[p]);
            end else begin
                fcyc += 4;
            end
            if (op <= 4) exp_wb.push_back(p);
            if (op == 7 || p == len) break;
        end
    endtask

    // Runs one program; answers DIV/MOD with alu_done in WAIT cycle dly[k].
    task automatic run_prog(input logic [3:0] len, input bit rnd);
        int pos, k, d;
        bit prev_e, e, a, isdiv, fin;
        wb_q.delete();
        act_cyc = 0;
        pos = -1; k = -1; d = 0; prev_e = 1'b1; isdiv = 1'b0; fin = 1'b0;
        prog_len = len;
        step(1, 1, 0);
        for (int c = 0; c < 2000 && !fin; c++) begin
            if (pos >= 0 && prev_e) pos++;
            e = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
            a = isdiv && e && (pos == d + 1);
            if (rnd && !e && $urandom_range(0, 1) == 1) a = 1'b1;
            if (rnd && e && pos == 1 && $urandom_range(0, 1) == 1) a = 1'b1;
            step(e, 0, a);
            prev_e = e;
            if (dec_ena && k < 15) begin
                pos = 0;
                k++;
                isdiv = (mem[k][7:5] == 3'd3) || (mem[k][7:5] == 3'd4);
                d = int'(dly[k]);
            end
            if (done) fin = 1'b1;
        end
        if (!fin) chk("run_budget_done", 0, 1);
    endtask

    task automatic verify(input string tag, input int ewb, input int epc, input int eerr,
                          input int ecyc, input bit use_q);
        chk({tag, "_wb_count"}, wb_q.size(), ewb);
        if (use_q)
            for (int i = 0; i < wb_q.size() && i < exp_wb.size(); i++)
                chk({tag, "_wb_pc"}, wb_q[i], exp_wb[i]);
        chk({tag, "_pc"}, 32'(pc), epc);
        chk({tag, "_error"}, 32'(error), eerr);
        chk({tag, "_done"}, 32'(done), 1);
        chk({tag, "_busy"}, 32'(busy), 0);
        chk({tag, "_cycles"}, act_cyc, ecyc);
    endtask

    initial begin
        int fpc, ferr, fcyc;
        for (int i = 0; i < 16; i++) begin mem[i] = 8'h00; dly[i] = 5'd0; end

        tbl[0] = '{prog:'0, dl:'0, len:4'd15, n_wb:2,  fpc:2,  ferr:0, cyc:12};
        tbl[0].prog[0] = 8'h03; tbl[0].prog[1] = 8'h25; tbl[0].prog[2] = 8'hE0;
        tbl[1] = '{prog:'0, dl:'0, len:4'd0,  n_wb:1,  fpc:0,  ferr:0, cyc:7};
        tbl[1].prog[0] = 8'h62; tbl[1].dl[0] = 5'd3;
        tbl[2] = '{prog:'0, dl:'0, len:4'd0,  n_wb:0,  fpc:0,  ferr:1, cyc:18};
        tbl[2].prog[0] = 8'h62; tbl[2].dl[0] = 5'd31;
        tbl[3] = '{prog:'0, dl:'0, len:4'd1,  n_wb:0,  fpc:1,  ferr:0, cyc:8};
        tbl[3].prog[0] = 8'hA1; tbl[3].prog[1] = 8'hC0;
        tbl[4] = '{prog:'0, dl:'0, len:4'd15, n_wb:16, fpc:15, ferr:0, cyc:64};
        tbl[5] = '{prog:'0, dl:'0, len:4'd15, n_wb:1,  fpc:1,  ferr:0, cyc:23};
        tbl[5].prog[0] = 8'h80; tbl[5].dl[0] = 5'd15; tbl[5].prog[1] = 8'hE0;
        tbl[6] = '{prog:'0, dl:'0, len:4'd5,  n_wb:2,  fpc:4,  ferr:1, cyc:35};
        tbl[6].prog[0] = 8'h40; tbl[6].prog[1] = 8'hA0; tbl[6].prog[2] = 8'h60;
        tbl[6].dl[2] = 5'd1;    tbl[6].prog[3] = 8'hC0; tbl[6].prog[4] = 8'h9F;
        tbl[6].dl[4] = 5'd16;
        tbl[7] = '{prog:'0, dl:'0, len:4'd0,  n_wb:1,  fpc:0,  ferr:0, cyc:4};
        tbl[7].prog[1] = 8'h62;

        // Reset state
        repeat (2) @(posedge clock);
        #1 reset = 1'b0;
        @(negedge clock);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_error", 32'(error), 0);
        chk("rst_pc", 32'(pc), 0);
        chk("rst_dec_instr", 32'(dec_instr), 0);
        chk("rst_dec_ena", 32'(dec_ena), 0);
        chk("rst_wb_strobe", 32'(wb_strobe), 0);

        // Directed program table
        for (int v = 0; v < 8; v++) begin
            for (int i = 0; i < 16; i++) begin mem[i] = tbl[v].prog[i]; dly[i] = tbl[v].dl[i]; end
            run_prog(tbl[v].len, 1'b0);
            verify($sformatf("tbl%0d", v), tbl[v].n_wb, tbl[v].fpc, tbl[v].ferr, tbl[v].cyc, 1'b0);
        end

        // Stall in WAIT with alu_done pulsed while ena low; counter must not advance
        for (int i = 0; i < 16; i++) mem[i] = 8'h00;
        mem[0] = 8'h62;
        wb_q.delete(); act_cyc = 0; prog_len = 4'd0;
        step(1, 1, 0);
        wait_dec("stall");
        step(1, 0, 0);
        step(1, 0, 0);
        for (int i = 0; i < 5; i++) begin
            step(0, 0, i == 2);
            chk("stall_busy", 32'(busy), 1);
            chk("stall_wb", 32'(wb_strobe), 0);
        end
        chk("stall_pc", 32'(pc), 0);
        for (int j = 2; j <= 14; j++) step(1, 0, 0);
        chk("stall_no_early_wb", wb_q.size(), 0);
        chk("stall_no_timeout", 32'(error), 0);
        step(1, 0, 1);
        step(1, 0, 0);
        chk("stall_wb_strobe", 32'(wb_strobe), 1);
        step(1, 0, 0);
        chk("stall_done", 32'(done), 1);
        chk("stall_error", 32'(error), 0);
        chk("stall_cycles", act_cyc, 19);

        // start while busy ignored, then reset in EXEC
        mem[0] = 8'h00; mem[1] = 8'h00; mem[2] = 8'hE0;
        prog_len = 4'd15;
        step(1, 1, 0);
        wait_dec("busy0");
        wait_dec("busy1");
        step(1, 1, 0);
        step(1, 0, 0);
        chk("busy_start_pc", 32'(pc), 1);
        chk("busy_start_wb", 32'(wb_strobe), 1);
        wait_dec("busy2");
        step(1, 0, 0);
        #1 reset = 1'b1;
        #1;
        chk("exec_rst_busy", 32'(busy), 0);
        chk("exec_rst_pc", 32'(pc), 0);
        chk("exec_rst_addr", 32'(imem_addr), 0);
        chk("exec_rst_dec_instr", 32'(dec_instr), 0);
        chk("exec_rst_dec_ena", 32'(dec_ena), 0);
        chk("exec_rst_wb", 32'(wb_strobe), 0);
        chk("exec_rst_done", 32'(done), 0);
        chk("exec_rst_error", 32'(error), 0);
        @(posedge clock);
        #1 reset = 1'b0;
        wb_q.delete();
        repeat (5) step(1, 0, 0);
        chk("post_rst_no_wb", wb_q.size(), 0);
        chk("post_rst_idle", 32'(busy), 0);
        chk("post_rst_not_done", 32'(done), 0);

        // Random programs with stalls and stray alu_done pulses
        for (int r = 0; r < 40; r++) begin
            logic [3:0] len;
            for (int i = 0; i < 16; i++) begin
                mem[i] = 8'($urandom);
                dly[i] = 5'($urandom_range(1, 17));
            end
            len = 4'($urandom_range(0, 15));
            model(int'(len), fpc, ferr, fcyc);
            run_prog(len, 1'b1);
            verify($sformatf("rnd%0d", r), exp_wb.size(), fpc, ferr, fcyc, 1'b1);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/instr_sequencer.md
INSTR_SEQUENCER -- requirements
Module: instr_sequencer

Interface
REQ-001 SHALL have port: clock  input  1  rising-edge system clock.
REQ-002 SHALL have port: reset  input  1  asynchronous, active-high reset.
REQ-003 SHALL have port: ena  input  1  global enable; low = stall (state, PC, counters frozen).
REQ-004 SHALL have port: start  input  1  one-cycle pulse; launches program from PC=0.
REQ-005 SHALL have port: prog_len  input  4  index of last instruction (0..15); sampled at start.
REQ-006 SHALL have port: imem_addr  output  4  instruction memory address (= PC).
REQ-007 SHALL have port: imem_data  input  8  instruction word; synchronous memory, valid 1 cycle after imem_addr.
REQ-008 SHALL have port: dec_instr  output  8  instruction presented to decoder.
REQ-009 SHALL have port: dec_ena  output  1  decoder enable strobe, 1 cycle per instruction.
REQ-010 SHALL have port: alu_done  input  1  ALU completion pulse for multi-cycle ops.
REQ-011 SHALL have port: wb_strobe  output  1  register write-back commit, 1 cycle.
REQ-012 SHALL have ports: busy, done, error  output  1 each  status; pc  output  4  current PC.
REQ-013 SHALL have parameter: TIMEOUT, default 15, max cycles waiting on alu_done.

Function
REQ-014 SHALL implement states IDLE, FETCH, DECODE, EXEC, WAIT, WB, HALT.
REQ-015 IDLE: start=1 -> FETCH, pc<=0, latch prog_len, clear error; else hold.
REQ-016 FETCH: imem_addr=pc; next cycle -> DECODE.
REQ-017 DECODE: dec_instr<=imem_data, dec_ena=1 for exactly this cycle; -> EXEC.
REQ-018 EXEC: opcode = dec_instr[7:5]; 011 (DIV) or 100 (MOD) -> WAIT; all others -> WB.
REQ-019 WAIT: alu_done=1 -> WB; wait counter reaching TIMEOUT without alu_done -> error<=1, -> HALT, no write-back.
REQ-020 WB: wb_strobe=1 iff opcode in 000..100; 101 (CMP), 110 (NOP) -> no strobe.
REQ-021 WB exit: opcode 111 (HALT) or pc==latched prog_len or pc==15 -> HALT; else pc<=pc+1, -> FETCH; PC never wraps.
REQ-022 HALT: done=1, busy=0; start=1 -> FETCH with pc<=0, done<=0, error<=0, re-latch prog_len.
REQ-023 busy=1 in FETCH, DECODE, EXEC, WAIT, WB; 0 in IDLE, HALT.
REQ-024 Per-instruction latency: 4 cycles (FETCH..WB) single-cycle ops; 4 + wait cycles for DIV/MOD.
REQ-025 ena=0: all registers hold; dec_ena and wb_strobe forced 0; WAIT counter frozen; alu_done ignored.
REQ-026 start while busy SHALL be ignored.
REQ-027 alu_done outside WAIT SHALL be ignored.
REQ-028 Wait counter SHALL clear on every entry to WAIT.

Reset
REQ-029 reset SHALL force state=IDLE, pc=0, dec_instr=8'h00, dec_ena=0, wb_strobe=0, busy=0, done=0, error=0, wait counter=0, latched prog_len=0.
REQ-030 reset mid-operation SHALL abort immediately with no further strobes; restart requires start.

Structure
REQ-031 Shared package SHALL hold state enum, opcode constants (ADD..CMP, NOP=110, HALT=111), TIMEOUT default.
REQ-032 Wait timeout counter SHALL be sub-module seq_watchdog (clear, count-enable, expired output).
REQ-033 Target size 150-300 lines RTL; single clock domain, no latches.

Verification
REQ-034 Program {8'h03 ADD, 8'h25 SUB, 8'hE0 HALT}, prog_len=15, start -> 2 wb_strobes, done after 12 cycles, pc=2.
REQ-035 DIV 8'h62, alu_done 3 cycles after WAIT entry -> one wb_strobe, 7-cycle instruction latency.
REQ-036 DIV with no alu_done, TIMEOUT=15 -> error=1, done=1, no wb_strobe, after 15 WAIT cycles.
REQ-037 CMP 8'hA1 then NOP 8'hC0, prog_len=1 -> zero wb_strobes, HALT at pc=1.
REQ-038 ena low 5 cycles during WAIT, alu_done pulsed while low -> pulse ignored, state/counter unchanged; completes on later alu_done.
REQ-039 reset asserted in EXEC -> all outputs at reset values same cycle; start pulse during busy ignored.
